// File: rtl/ram8_access_scheduler.sv
// Round-robin scheduler sharing one 8-entry register bank between NUM_REQ requesters.
// Each transaction runs IDLE (arbitrate) -> ISSUE (bank access) -> RESP (ack).
module ram8_access_scheduler #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned PTR_W   = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ-1:0]       req_we,
  input  logic [3*NUM_REQ-1:0]     req_addr,
  input  logic [WIDTH*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]       ack,
  output logic [WIDTH-1:0]         rsp_rdata,
  output logic                     busy,
  output logic [2:0]               ram_addr,
  output logic                     ram_load,
  output logic [WIDTH-1:0]         ram_in,
  input  logic [WIDTH-1:0]         ram_out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]     win_q, win_d;
  logic                 we_q, we_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic [WIDTH-1:0]     rsp_q, rsp_d;
  logic                 busy_q, busy_d;
  logic [2:0]           ram_addr_q, ram_addr_d;
  logic                 ram_load_q, ram_load_d;
  logic [WIDTH-1:0]     ram_in_q, ram_in_d;

  logic [2*NUM_REQ-1:0] rot_c;
  logic                 found_c;
  logic [PTR_W-1:0]     pick_c;
  logic [31:0]          pick_sum_c;
  logic                 sel_we_c;
  logic [2:0]           sel_addr_c;
  logic [WIDTH-1:0]     sel_wdata_c;

  // Rotate requests so the scan starts at rr_ptr; first set bit wins
  always_comb begin
    rot_c      = {req, req} >> rr_ptr_q;
    found_c    = 1'b0;
    pick_c     = '0;
    pick_sum_c = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!found_c && rot_c[k]) begin
        found_c    = 1'b1;
        pick_sum_c = 32'(rr_ptr_q) + 32'(k);
        if (pick_sum_c >= 32'(NUM_REQ)) pick_sum_c = pick_sum_c - 32'(NUM_REQ);
        pick_c     = PTR_W'(pick_sum_c);
      end
    end
  end

  // Operand mux for the selected requester
  always_comb begin
    sel_we_c    = 1'b0;
    sel_addr_c  = '0;
    sel_wdata_c = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (PTR_W'(j) == pick_c) begin
        sel_we_c    = req_we[j];
        sel_addr_c  = req_addr[3*j +: 3];
        sel_wdata_c = req_wdata[WIDTH*j +: WIDTH];
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (found_c) state_d = S_ISSUE;
      S_ISSUE: state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath next values; bank address and data hold between transactions
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    win_d      = win_q;
    we_d       = we_q;
    ack_d      = ack_q;
    rsp_d      = rsp_q;
    busy_d     = busy_q;
    ram_addr_d = ram_addr_q;
    ram_load_d = ram_load_q;
    ram_in_d   = ram_in_q;
    case (state_q)
      S_IDLE: begin
        if (found_c) begin
          win_d      = pick_c;
          we_d       = sel_we_c;
          ram_addr_d = sel_addr_c;
          ram_in_d   = sel_wdata_c;
          ram_load_d = sel_we_c;
          busy_d     = 1'b1;
        end
      end
      S_ISSUE: begin
        if (!we_q) rsp_d = ram_out;
        ram_load_d = 1'b0;
        ack_d      = NUM_REQ'(1) << win_q;
      end
      S_RESP: begin
        ack_d    = '0;
        busy_d   = 1'b0;
        rr_ptr_d = (win_q == PTR_W'(NUM_REQ - 1)) ? '0 : win_q + PTR_W'(1);
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q   <= '0;
      win_q      <= '0;
      we_q       <= 1'b0;
      ack_q      <= '0;
      rsp_q      <= '0;
      busy_q     <= 1'b0;
      ram_addr_q <= '0;
      ram_load_q <= 1'b0;
      ram_in_q   <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      win_q      <= win_d;
      we_q       <= we_d;
      ack_q      <= ack_d;
      rsp_q      <= rsp_d;
      busy_q     <= busy_d;
      ram_addr_q <= ram_addr_d;
      ram_load_q <= ram_load_d;
      ram_in_q   <= ram_in_d;
    end
  end

  assign ack       = ack_q;
  assign rsp_rdata = rsp_q;
  assign busy      = busy_q;
  assign ram_addr  = ram_addr_q;
  assign ram_load  = ram_load_q;
  assign ram_in    = ram_in_q;

endmodule

// File: tb/tb_ram8_access_scheduler.sv
// Bench for ram8_access_scheduler: directed scenarios plus random traffic
// checked against a transaction-level model of arbitration and the bank.
module tb_ram8_access_scheduler;
  localparam int N = 4;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req, req_we;
  logic [3*N-1:0] req_addr;
  logic [W*N-1:0] req_wdata;
  logic [N-1:0]   ack;
  logic [W-1:0]   rsp_rdata;
  logic           busy;
  logic [2:0]     ram_addr;
  logic           ram_load;
  logic [W-1:0]   ram_in;
  logic [W-1:0]   ram_out;

  ram8_access_scheduler #(.NUM_REQ(N), .WIDTH(W), .PTR_W(2)) dut (
    .clk(clk), .reset(reset), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .ack(ack), .rsp_rdata(rsp_rdata), .busy(busy),
    .ram_addr(ram_addr), .ram_load(ram_load), .ram_in(ram_in), .ram_out(ram_out)
  );

  always #5 clk = ~clk;

  // Register bank: write on load strobe, combinational read; unaffected by scheduler reset
  logic [W-1:0] bank [8];
  logic         bank_clr;
  always @(posedge clk) begin
    if (bank_clr) for (int i = 0; i < 8; i++) bank[i] <= '0;
    else if (ram_load) bank[ram_addr] <= ram_in;
  end
  assign ram_out = bank[ram_addr];

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int         mdl_ptr;
  logic [W-1:0] mdl_mem [8];
  logic [W-1:0] mdl_rsp;
  logic [2:0]   mdl_addr;
  logic [W-1:0] mdl_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_agent(input int i, input logic we, input logic [2:0] a, input logic [W-1:0] d);
    req[i]             = 1'b1;
    req_we[i]          = we;
    req_addr[3*i +: 3] = a;
    req_wdata[W*i +: W] = d;
  endtask

  function automatic int model_pick();
    for (int k = 0; k < N; k++) begin
      if (req[(mdl_ptr + k) % N]) return (mdl_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    mdl_ptr  = 0;
    mdl_rsp  = '0;
    mdl_addr = '0;
    mdl_in   = '0;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_ack"}, 32'(ack), 32'd0);
    chk({tag, "_load"}, 32'(ram_load), 32'd0);
    chk({tag, "_addr"}, 32'(ram_addr), 32'(mdl_addr));
    chk({tag, "_in"}, 32'(ram_in), 32'(mdl_in));
    chk({tag, "_rsp"}, 32'(rsp_rdata), 32'(mdl_rsp));
  endtask

  // Called at a falling edge during an IDLE cycle with requests already driven
  task automatic serve(input string tag, input logic [N-1:0] late, input bit mut_wd, output int w);
    logic         op_we;
    logic [2:0]   op_addr;
    logic [W-1:0] op_wd;
    check_idle({tag, "_idle"});
    w = model_pick();
    if (w < 0) begin
      chk({tag, "_noreq"}, 32'd0, 32'd1);
      return;
    end
    op_we   = req_we[w];
    op_addr = req_addr[3*w +: 3];
    op_wd   = req_wdata[W*w +: W];
    @(negedge clk);
    chk({tag, "_iss_busy"}, 32'(busy), 32'd1);
    chk({tag, "_iss_load"}, 32'(ram_load), 32'(op_we));
    chk({tag, "_iss_addr"}, 32'(ram_addr), 32'(op_addr));
    chk({tag, "_iss_in"}, 32'(ram_in), 32'(op_wd));
    chk({tag, "_iss_ack"}, 32'(ack), 32'd0);
    if (mut_wd) req_wdata[W*w +: W] = 16'hFFFF;
    req = req | late;
    @(negedge clk);
    if (op_we) mdl_mem[op_addr] = op_wd;
    else       mdl_rsp = mdl_mem[op_addr];
    mdl_addr = op_addr;
    mdl_in   = op_wd;
    chk({tag, "_rsp_ack"}, 32'(ack), 32'(1) << w);
    chk({tag, "_rsp_busy"}, 32'(busy), 32'd1);
    chk({tag, "_rsp_load"}, 32'(ram_load), 32'd0);
    chk({tag, "_rsp_data"}, 32'(rsp_rdata), 32'(mdl_rsp));
    chk({tag, "_rsp_in"}, 32'(ram_in), 32'(op_wd));
    req[w]  = 1'b0;
    mdl_ptr = (w + 1) % N;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    @(negedge clk);
    @(negedge clk);
    model_reset();
    check_idle("reset");
    reset = 1'b0;
  endtask

  initial begin
    int w;
    reset = 1'b1; req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    bank_clr = 1'b1;
    for (int i = 0; i < 8; i++) mdl_mem[i] = '0;
    @(negedge clk);
    bank_clr = 1'b0;
    do_reset();

    // Write then read back, single requester
    set_agent(0, 1'b1, 3'd5, 16'hBEEF);
    serve("t1_wr", '0, 1'b0, w);
    set_agent(0, 1'b0, 3'd5, 16'h0000);
    serve("t1_rd", '0, 1'b0, w);
    chk("t1_rdata", 32'(rsp_rdata), 32'h0000_BEEF);

    // All four requesters from reset
    do_reset();
    for (int i = 0; i < N; i++) set_agent(i, 1'($urandom), 3'($urandom), 16'($urandom));
    for (int i = 0; i < N; i++) serve("t2", '0, 1'b0, w);
    chk("t2_drained", 32'(req), 32'd0);

    // Rotation: requester 1 continuous, requester 3 arrives while 1 is served
    set_agent(1, 1'b0, 3'd5, 16'h1111);
    req_we[3] = 1'b0; req_addr[9 +: 3] = 3'd5; req_wdata[48 +: 16] = 16'h3333;
    serve("t3_a", 4'b1000, 1'b0, w);
    set_agent(1, 1'b0, 3'd5, 16'h1111);
    serve("t3_b", '0, 1'b0, w);
    serve("t3_c", '0, 1'b0, w);

    // Operands latched at grant
    set_agent(2, 1'b1, 3'd2, 16'h1234);
    serve("t4_wr", '0, 1'b1, w);
    set_agent(2, 1'b0, 3'd2, 16'h0000);
    serve("t4_rd", '0, 1'b0, w);
    chk("t4_rdata", 32'(rsp_rdata), 32'h0000_1234);

    // Reset during ISSUE of a write
    set_agent(2, 1'b0, 3'd1, 16'h0000);
    serve("t5_pre", '0, 1'b0, w);
    set_agent(0, 1'b1, 3'd7, 16'h00AA);
    @(negedge clk);
    chk("t5_iss_load", 32'(ram_load), 32'd1);
    chk("t5_iss_addr", 32'(ram_addr), 32'd7);
    reset = 1'b1;
    req   = '0;
    @(negedge clk);
    reset = 1'b0;
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_load", 32'(ram_load), 32'd0);
    chk("t5_ack", 32'(ack), 32'd0);
    chk("t5_bank", 32'(bank[7]), 32'h0000_00AA);
    model_reset();
    mdl_mem[7] = 16'h00AA;
    set_agent(1, 1'b0, 3'd7, 16'h0101);
    set_agent(3, 1'b0, 3'd7, 16'h0303);
    serve("t5_ptr", '0, 1'b0, w);
    chk("t5_rdata", 32'(rsp_rdata), 32'h0000_00AA);
    serve("t5_nxt", '0, 1'b0, w);

    // Idle stability
    req = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check_idle("t6");
    end

    // Random traffic
    for (int it = 0; it < 150; it++) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i] && ($urandom % 2 == 0))
          set_agent(i, 1'($urandom), 3'($urandom), 16'($urandom));
      end
      if (req == '0) set_agent(int'($urandom % N), 1'($urandom), 3'($urandom), 16'($urandom));
      serve("rnd", N'($urandom) & N'($urandom), 1'($urandom), w);
    end
    req = '0;
    @(negedge clk);
    check_idle("end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
